// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one iteration per clock).
// Optional digit range check enabled by defining BCD_TO_BIN_DIGIT_CHECK_EN.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  invalid
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [BCD_W-1:0]   bcd_reg, bcd_nx, bcd_sh, bcd_cor;
    logic [BIN_W-1:0]   bin_reg, bin_nx, bin_sh;
    logic [BIN_W-1:0]   bin_out_reg, bin_out_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               busy_reg, busy_nx;
    logic               done_reg, done_nx;
    logic               load, finish;

    // One iteration: shift W right, then subtract 3 from every digit that became >= 8.
    always_comb begin
        bcd_sh  = {1'b0, bcd_reg[BCD_W-1:1]};
        bin_sh  = {bcd_reg[0], bin_reg[BIN_W-1:1]};
        bcd_cor = bcd_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_sh[4*d+3]) begin
                bcd_cor[4*d +: 4] = bcd_sh[4*d +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
    logic err_reg, invalid_reg, digit_bad;

    always_comb begin
        digit_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_reg     <= 1'b0;
            invalid_reg <= 1'b0;
        end else begin
            if (load) begin
                err_reg <= digit_bad;
            end
            if (finish) begin
                invalid_reg <= err_reg;
            end
        end
    end

    assign invalid = invalid_reg;
`else
    assign invalid = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        bcd_nx     = bcd_reg;
        bin_nx     = bin_reg;
        cnt_nx     = cnt;
        bin_out_nx = bin_out_reg;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                    bcd_nx   = bcd_in;
                    bin_nx   = '0;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            SHIFT: begin
                bcd_nx = bcd_cor;
                bin_nx = bin_sh;
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                    done_nx  = 1'b1;
`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
                    bin_out_nx = err_reg ? '0 : bin_sh;
`else
                    bin_out_nx = bin_sh;
`endif
                end else begin
                    busy_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bcd_reg     <= '0;
            bin_reg     <= '0;
            cnt         <= '0;
            bin_out_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state       <= state_nx;
            bcd_reg     <= bcd_nx;
            bin_reg     <= bin_nx;
            cnt         <= cnt_nx;
            bin_out_reg <= bin_out_nx;
            busy_reg    <= busy_nx;
            done_reg    <= done_nx;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign bin_out = bin_out_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7); digit-check cases run when
// BCD_TO_BIN_DIGIT_CHECK_EN is defined.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                invalid;

    logic [BIN_W-1:0] exp_q[$];
    logic             inv_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int prev_done_cyc = 0;
    bit have_prev = 0;
    bit in_b2b = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .invalid (invalid)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // scoreboard: pop expected result on every done pulse
    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            chk("pending_on_done", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk("bin_out", 32'(bin_out), 32'(exp_q.pop_front()));
                chk("invalid", 32'(invalid), 32'(inv_q.pop_front()));
            end
            if (in_b2b && have_prev) begin
                chk("b2b_period", cyc - prev_done_cyc, 8);
            end
            prev_done_cyc = cyc;
            have_prev     = 1'b1;
        end
    end

    // driver: called at a negedge, start is accepted at the following posedge
    task automatic start_conv(input logic [7:0] bcd, input logic [BIN_W-1:0] want, input logic inv);
        bcd_in = bcd;
        start  = 1'b1;
        exp_q.push_back(want);
        inv_q.push_back(inv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 30) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        int lat, bcnt, dc;
        reset_n = 1'b0;
        start   = 1'b0;
        bcd_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bin_out", 32'(bin_out), 0);
        chk("rst_invalid", 32'(invalid), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_bin_out", 32'(bin_out), 0);

        // directed conversions with latency checks
        start_conv(8'h99, 7'd99, 1'b0);
        wait_done(lat, bcnt);
        chk("busy_cycles_99", bcnt, 7);
        chk("latency_99", lat, 7);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
        chk("bin_out_held", 32'(bin_out), 99);

        start_conv(8'h47, 7'd47, 1'b0);
        wait_done(lat, bcnt);
        chk("latency_47", lat, 7);
        @(negedge clk);
        start_conv(8'h00, 7'd0, 1'b0);
        wait_done(lat, bcnt);
        @(negedge clk);
        start_conv(8'h10, 7'd10, 1'b0);
        wait_done(lat, bcnt);
        @(negedge clk);

        // exhaustive back-to-back, start raised in each DONE cycle
        in_b2b    = 1'b1;
        have_prev = 1'b0;
        dc = done_cnt;
        start_conv(to_bcd(0), 7'd0, 1'b0);
        for (int v = 1; v <= 99; v++) begin
            wait_done(lat, bcnt);
            start_conv(to_bcd(v), 7'(v), 1'b0);
        end
        wait_done(lat, bcnt);
        @(negedge clk);
        in_b2b = 1'b0;
        chk("b2b_done_count", done_cnt - dc, 100);

        // start and bcd_in changes mid-conversion are ignored
        repeat (2) @(negedge clk);
        dc = done_cnt;
        start_conv(8'h25, 7'd25, 1'b0);
        repeat (2) @(negedge clk);
        bcd_in = 8'h88;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        repeat (12) @(negedge clk);
        chk("single_done", done_cnt - dc, 1);
        chk("no_restart_busy", 32'(busy), 0);

        // reset in the middle of a conversion aborts it
        dc = done_cnt;
        start_conv(8'h63, 7'd63, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        inv_q.delete();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_bin_out", 32'(bin_out), 0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - dc, 0);
        start_conv(8'h12, 7'd12, 1'b0);
        wait_done(lat, bcnt);
        chk("latency_12", lat, 7);
        @(negedge clk);

        // a few random legal values
        for (int i = 0; i < 8; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            start_conv(to_bcd(r), 7'(r), 1'b0);
            wait_done(lat, bcnt);
            @(negedge clk);
        end

`ifdef BCD_TO_BIN_DIGIT_CHECK_EN
        start_conv(8'h3A, 7'd0, 1'b1);
        wait_done(lat, bcnt);
        @(negedge clk);
        chk("invalid_held", 32'(invalid), 1);
        start_conv(8'h31, 7'd31, 1'b0);
        wait_done(lat, bcnt);
        @(negedge clk);
        chk("invalid_cleared", 32'(invalid), 0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD path (6-bit to tens/ones).
Implements reverse double-dabble: one shift-right/correct iteration per clock, with a start/busy/done handshake.
Sits between BCD entry logic (switch/keypad digit registers) and binary arithmetic datapaths.
Default configuration converts two BCD digits (00-99) to a 7-bit binary value.

Parameters:
DIGITS, 2, number of BCD digits in bcd_in (1..4)
BIN_W, 7, binary result width; must satisfy 10^DIGITS-1 < 2^BIN_W; also equals the iteration count

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  request conversion; sampled in IDLE or DONE only
bcd_in  input  4*DIGITS  packed BCD, digit 0 (ones) in [3:0], tens in [7:4], ...
busy  output  1  high while iterating
done  output  1  one-cycle pulse; result valid
bin_out  output  BIN_W  binary result, held until next accepted start
invalid  output  1  digit >9 flag (see Optional Feature)

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clk, reset_n).
- Reset (reset_n=0 at a rising edge): state=IDLE; busy=0, done=0, bin_out=0, invalid=0; iteration counter=0; work registers=0. Reset mid-conversion aborts it; no done pulse follows.
- Work register W = {bcd_reg[4*DIGITS-1:0], bin_reg[BIN_W-1:0]}.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE: if start=1 at an edge, load bcd_reg<=bcd_in, bin_reg<=0, cnt<=0, go SHIFT. Otherwise DONE->IDLE and IDLE holds.
- SHIFT, each cycle: W <= W >> 1 (bcd_reg LSB enters bin_reg MSB; 0 enters bcd_reg MSB). Then each 4-bit digit of the shifted bcd_reg that is >=8 has 3 subtracted. This is a combinational correction applied in the same cycle, before registering. cnt<=cnt+1.
- When cnt reaches BIN_W-1 in SHIFT: that iteration completes, bin_out <= final bin_reg value, go DONE.
- Timing: start sampled at edge k. busy=1 during cycles k+1..k+BIN_W. done=1 during cycle k+BIN_W+1 only. bin_out updates at the same edge done rises.
- busy is a registered output; busy=0 in IDLE and DONE.
- start while busy=1: ignored. bcd_in changes while busy: no effect, because the input is captured at start.
- start asserted in the DONE cycle: accepted; the next conversion begins immediately (back-to-back throughput is one result per BIN_W+1 cycles).
- bin_out is stable from done until the edge that completes the next conversion. It is not cleared on start.
- The counter is sized clog2(BIN_W) bits and never wraps in normal operation.

Optional Feature:
Macro BCD_TO_BIN_DIGIT_CHECK_EN.
- Defined: at the accepting start edge, each digit of bcd_in is compared against >9 and the OR is registered as err_reg. The conversion runs normally. At the done edge, invalid <= err_reg. If err_reg=1, bin_out <= 0 instead of the computed value. invalid holds with bin_out until the next done edge, and is cleared by reset.
- Not defined: no check logic. invalid tied to 0. Digits >9 yield an unspecified (but deterministic) bin_out.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> busy=0, done=0, bin_out=0, invalid=0. Release, idle 5 cycles -> no change.
- DIGITS=2: start with bcd_in=8'h99 -> busy high exactly 7 cycles, done pulses on cycle 8 after start, bin_out=7'd99. Repeat 8'h47 -> 47; 8'h00 -> 0; 8'h10 -> 10.
- Exhaustive 00-99, back-to-back with start asserted in each DONE cycle -> each bin_out equals the decimal value; period 8 cycles; no missed done.
- start pulsed and bcd_in changed mid-conversion (8'h25, then 8'h88 at cycle 3) -> result 25, single done.
- Reset asserted at SHIFT cycle 4 of 8'h63 -> no done. Next start with 8'h12 -> 12.
- DIGITS=3, BIN_W=10: 12'h999 -> 999 after 10 busy cycles. With BCD_TO_BIN_DIGIT_CHECK_EN, 8'h3A -> invalid=1, bin_out=0; then 8'h31 -> invalid=0, bin_out=31.
